// File: rtl/zebra_pkg.sv
// rtl/zebra_pkg.sv - shared state encoding and sizing helpers for the zebra datapath
package zebra_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2,
    EVAL   = 2'd3
  } state_t;

  // White-count width, shared with the detector so both agree on CW.
  function automatic int count_width(input int img_width, input int img_height);
    return (img_width * img_height > 1) ? $clog2(img_width * img_height) : 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

endpackage

// File: rtl/zebra_hysteresis.sv
// rtl/zebra_hysteresis.sv - consecutive hit/miss streaks and debounced present flag
module zebra_hysteresis
  import zebra_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hit_valid,
  input  logic       hit,
  input  logic [7:0] cfg_on_frames,
  input  logic [7:0] cfg_off_frames,
  output logic       present
);

  logic [7:0] hit_streak;
  logic [7:0] miss_streak;
  logic [7:0] hit_next;
  logic [7:0] miss_next;
  logic [7:0] on_thr;
  logic [7:0] off_thr;

  // A threshold of zero would make the flag flap; treat it as one frame.
  assign on_thr  = (cfg_on_frames == 8'd0) ? 8'd1 : cfg_on_frames;
  assign off_thr = (cfg_off_frames == 8'd0) ? 8'd1 : cfg_off_frames;

  assign hit_next  = hit ? sat_inc8(hit_streak) : 8'd0;
  assign miss_next = hit ? 8'd0 : sat_inc8(miss_streak);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_streak  <= 8'd0;
      miss_streak <= 8'd0;
      present     <= 1'b0;
    end else if (hit_valid) begin
      hit_streak  <= hit_next;
      miss_streak <= miss_next;
      if (hit_next >= on_thr) begin
        present <= 1'b1;
      end else if (miss_next >= off_thr) begin
        present <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/zebra_frame_scheduler.sv
// rtl/zebra_frame_scheduler.sv - whole-frame gating, decimation and per-frame zebra decision
module zebra_frame_scheduler
  import zebra_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int W          = 8,
  parameter int CW         = count_width(IMG_WIDTH, IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic [W-1:0]  x_data,
  output logic          det_valid,
  input  logic          det_ready,
  output logic [W-1:0]  det_data,
  input  logic [CW-1:0] det_white_count,
  input  logic          cfg_enable,
  input  logic [7:0]    cfg_decimate,
  input  logic [CW-1:0] cfg_min_white,
  input  logic [CW-1:0] cfg_max_white,
  input  logic [7:0]    cfg_on_frames,
  input  logic [7:0]    cfg_off_frames,
  output logic          result_valid,
  output logic          frame_hit,
  output logic          zebra_present,
  output logic [CW-1:0] frame_white,
  output logic [15:0]   frames_processed,
  output logic [15:0]   frames_dropped
);

  localparam int            NPIX     = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] pix_cnt;
  logic [7:0]    dec_cnt;
  logic          frame_start;
  logic          last_pix;
  logic          selected;
  logic          x_fire;
  logic          window_hit;
  logic          in_eval;

  assign frame_start = (pix_cnt == '0);
  assign last_pix    = (pix_cnt == LAST_PIX);
  assign selected    = cfg_enable && (dec_cnt == 8'd0);
  assign x_fire      = x_valid && x_ready;
  assign det_data    = x_data;
  assign in_eval     = (state == EVAL);
  assign window_hit  = (det_white_count >= cfg_min_white) && (det_white_count <= cfg_max_white);

  always_comb begin
    state_next = state;
    x_ready    = 1'b1;
    det_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start && selected) begin
          det_valid = x_valid;
          x_ready   = det_ready;
          if (x_valid && det_ready) begin
            state_next = last_pix ? SETTLE : RUN;
          end
        end
      end
      RUN: begin
        det_valid = x_valid;
        x_ready   = det_ready;
        if (x_valid && det_ready && last_pix) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        x_ready    = 1'b0;
        state_next = EVAL;
      end
      EVAL: begin
        x_ready    = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      pix_cnt          <= '0;
      dec_cnt          <= 8'd0;
      result_valid     <= 1'b0;
      frame_hit        <= 1'b0;
      frame_white      <= '0;
      frames_processed <= 16'd0;
      frames_dropped   <= 16'd0;
    end else begin
      state        <= state_next;
      result_valid <= in_eval;

      // Every accepted pixel advances the raster position, forwarded or not.
      if (x_fire) begin
        pix_cnt <= last_pix ? '0 : pix_cnt + CW'(1);
      end

      if (state == IDLE && x_fire && frame_start) begin
        if (selected) begin
          dec_cnt <= cfg_decimate;
        end else begin
          dec_cnt        <= cfg_enable ? dec_cnt - 8'd1 : 8'd0;
          frames_dropped <= frames_dropped + 16'd1;
        end
      end

      if (in_eval) begin
        frame_white      <= det_white_count;
        frame_hit        <= window_hit;
        frames_processed <= frames_processed + 16'd1;
      end
    end
  end

  zebra_hysteresis u_hysteresis (
    .clk            (clk),
    .rst_n          (rst_n),
    .hit_valid      (in_eval),
    .hit            (window_hit),
    .cfg_on_frames  (cfg_on_frames),
    .cfg_off_frames (cfg_off_frames),
    .present        (zebra_present)
  );

endmodule

// File: tb/tb_zebra_frame_scheduler.sv
// tb/tb_zebra_frame_scheduler.sv - scoreboard bench for zebra_frame_scheduler on a 4x2 image
module tb_zebra_frame_scheduler;

  localparam int IW   = 4;
  localparam int IH   = 2;
  localparam int W    = 8;
  localparam int CW   = 3;
  localparam int NPIX = IW * IH;

  logic          clk;
  logic          rst_n;
  logic          x_valid;
  logic          x_ready;
  logic [W-1:0]  x_data;
  logic          det_valid;
  logic          det_ready;
  logic [W-1:0]  det_data;
  logic [CW-1:0] det_white_count;
  logic          cfg_enable;
  logic [7:0]    cfg_decimate;
  logic [CW-1:0] cfg_min_white;
  logic [CW-1:0] cfg_max_white;
  logic [7:0]    cfg_on_frames;
  logic [7:0]    cfg_off_frames;
  logic          result_valid;
  logic          frame_hit;
  logic          zebra_present;
  logic [CW-1:0] frame_white;
  logic [15:0]   frames_processed;
  logic [15:0]   frames_dropped;

  zebra_frame_scheduler #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .det_valid(det_valid), .det_ready(det_ready), .det_data(det_data),
    .det_white_count(det_white_count),
    .cfg_enable(cfg_enable), .cfg_decimate(cfg_decimate),
    .cfg_min_white(cfg_min_white), .cfg_max_white(cfg_max_white),
    .cfg_on_frames(cfg_on_frames), .cfg_off_frames(cfg_off_frames),
    .result_valid(result_valid), .frame_hit(frame_hit), .zebra_present(zebra_present),
    .frame_white(frame_white), .frames_processed(frames_processed), .frames_dropped(frames_dropped)
  );

  typedef struct {
    int cyc;
    int hit;
    int present;
    int white;
    int processed;
    int dropped;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   dv_cnt = 0;
  int   dhs_cnt = 0;
  int   hs_cyc = 0;
  bit   rand_ready = 0;

  // Reference model state: frame-level view of decimation and hysteresis.
  int m_dec, m_hs, m_ms, m_present, m_processed, m_dropped;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) det_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic void chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_dec = 0; m_hs = 0; m_ms = 0; m_present = 0; m_processed = 0; m_dropped = 0;
  endfunction

  function automatic bit model_frame_start();
    if (cfg_enable && m_dec == 0) begin
      m_dec = int'(cfg_decimate);
      return 1'b1;
    end
    m_dec = cfg_enable ? m_dec - 1 : 0;
    m_dropped = (m_dropped + 1) % 65536;
    return 1'b0;
  endfunction

  function automatic void model_frame_end(input int white, input int res_cyc);
    exp_t e;
    int on_t, off_t, hit;
    hit   = (white >= int'(cfg_min_white) && white <= int'(cfg_max_white)) ? 1 : 0;
    on_t  = (cfg_on_frames == 0) ? 1 : int'(cfg_on_frames);
    off_t = (cfg_off_frames == 0) ? 1 : int'(cfg_off_frames);
    if (hit == 1) begin
      m_hs = (m_hs < 255) ? m_hs + 1 : 255;
      m_ms = 0;
    end else begin
      m_ms = (m_ms < 255) ? m_ms + 1 : 255;
      m_hs = 0;
    end
    if (m_hs >= on_t) m_present = 1;
    else if (m_ms >= off_t) m_present = 0;
    m_processed = (m_processed + 1) % 65536;
    e.cyc = res_cyc; e.hit = hit; e.present = m_present; e.white = white;
    e.processed = m_processed; e.dropped = m_dropped;
    sb.push_back(e);
  endfunction

  // Monitor: forwarded data, detector handshakes and result scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (det_valid) begin
          dv_cnt++;
          chk("det_data", det_data, x_data);
          if (det_ready) dhs_cnt++;
        end
        if (result_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", result_valid, 0);
          end else begin
            e = sb.pop_front();
            chk("result_cycle", cyc, e.cyc);
            chk("frame_hit", frame_hit, e.hit);
            chk("zebra_present", zebra_present, e.present);
            chk("frame_white", frame_white, e.white);
            chk("frames_processed", frames_processed, e.processed);
            chk("frames_dropped", frames_dropped, e.dropped);
          end
        end
      end
    end
  end

  task automatic send_pixel(output int waits);
    int n;
    n = 0;
    x_data  = W'($urandom);
    x_valid = 1'b1;
    @(negedge clk);
    while (!x_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (!x_ready) chk("handshake_timeout", x_ready, 1);
    waits  = n;
    hs_cyc = cyc;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
  endtask

  task automatic send_frame(input int white, input int npix, output bit sel);
    int waits, total_waits;
    sel = 1'b0;
    total_waits = 0;
    dv_cnt = 0;
    dhs_cnt = 0;
    det_white_count = CW'(white);
    for (int p = 0; p < npix; p++) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
      send_pixel(waits);
      total_waits += waits;
      if (p == 0) sel = model_frame_start();
    end
    if (npix == NPIX) begin
      if (sel) begin
        model_frame_end(white, hs_cyc + 3);
        @(negedge clk);
        chk("settle_x_ready", x_ready, 0);
        chk("settle_det_valid", det_valid, 0);
        @(negedge clk);
        chk("eval_x_ready", x_ready, 0);
        @(posedge clk);
        #1;
      end
      repeat (4) begin
        @(posedge clk);
        #1;
      end
      chk("det_handshakes", dhs_cnt, sel ? NPIX : 0);
      if (!sel) begin
        chk("drop_det_valid_cycles", dv_cnt, 0);
        chk("drop_stall_cycles", total_waits, 0);
      end
    end
  endtask

  task automatic check_reset_values();
    chk("rst_det_valid", det_valid, 0);
    chk("rst_x_ready", x_ready, 1);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_frame_hit", frame_hit, 0);
    chk("rst_zebra_present", zebra_present, 0);
    chk("rst_frame_white", frame_white, 0);
    chk("rst_frames_processed", frames_processed, 0);
    chk("rst_frames_dropped", frames_dropped, 0);
  endtask

  bit dec_exp[6]    = '{1, 0, 0, 1, 0, 0};
  bit hyst_hit[8]   = '{1, 1, 0, 1, 1, 1, 0, 0};
  bit hyst_pres[8]  = '{0, 0, 0, 0, 0, 1, 1, 0};

  initial begin
    bit   sel;
    int   w0, drop0, waits;
    rst_n = 1'b0;
    x_valid = 1'b0;
    x_data = '0;
    det_ready = 1'b1;
    det_white_count = '0;
    cfg_enable = 1'b1;
    cfg_decimate = 8'd0;
    cfg_min_white = CW'(3);
    cfg_max_white = CW'(5);
    cfg_on_frames = 8'd1;
    cfg_off_frames = 8'd1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_ready = 1'b1;

    // Basic processed frame.
    send_frame(4, NPIX, sel);
    chk("t1_selected", sel, 1);
    chk("t1_frame_hit", frame_hit, 1);
    chk("t1_present", zebra_present, 1);
    chk("t1_frame_white", frame_white, 4);
    chk("t1_processed", frames_processed, 1);

    // Decimation by 2 over six frames.
    cfg_decimate = 8'd2;
    drop0 = int'(frames_dropped);
    for (int f = 0; f < 6; f++) begin
      send_frame($urandom_range(0, 7), NPIX, sel);
      chk("dec_selected", sel, dec_exp[f]);
    end
    chk("dec_dropped_delta", int'(frames_dropped) - drop0, 4);

    // Reset in the middle of a selected frame, then an aligned frame.
    cfg_decimate = 8'd0;
    cfg_on_frames = 8'd3;
    cfg_off_frames = 8'd2;
    send_frame(0, NPIX, sel);
    send_frame(4, 6, sel);
    chk("mid_reset_frame_selected", sel, 1);
    rand_ready = 1'b0;
    det_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    sb.delete();
    rand_ready = 1'b1;
    send_frame(0, NPIX, sel);
    chk("post_reset_selected", sel, 1);
    chk("post_reset_processed", frames_processed, 1);

    // Hysteresis H,H,M,H,H,H,M,M with on=3, off=2.
    for (int f = 0; f < 8; f++) begin
      send_frame(hyst_hit[f] ? 4 : 0, NPIX, sel);
      chk("hyst_present", zebra_present, hyst_pres[f]);
    end

    // First pixel stalled by the detector, then the frame is deselected.
    rand_ready = 1'b0;
    det_ready = 1'b0;
    dv_cnt = 0;
    dhs_cnt = 0;
    x_data = W'($urandom);
    x_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_x_ready", x_ready, 0);
      chk("stall_det_valid", det_valid, 1);
    end
    @(posedge clk);
    #1;
    cfg_enable = 1'b0;
    @(negedge clk);
    chk("disable_x_ready", x_ready, 1);
    chk("disable_det_valid", det_valid, 0);
    sel = model_frame_start();
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    for (int p = 1; p < NPIX; p++) begin
      send_pixel(waits);
      chk("disable_no_stall", waits, 0);
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("disable_det_handshakes", dhs_cnt, 0);
    chk("disable_dropped", frames_dropped, m_dropped);
    cfg_enable = 1'b1;
    rand_ready = 1'b1;

    // Empty window: min above max.
    cfg_min_white = CW'(6);
    cfg_max_white = CW'(2);
    for (int f = 0; f < 3; f++) begin
      send_frame($urandom_range(0, 7), NPIX, sel);
      chk("empty_window_hit", frame_hit, 0);
    end

    // Randomized frames and configuration.
    for (int f = 0; f < 80; f++) begin
      cfg_enable     = ($urandom_range(0, 7) != 0);
      cfg_decimate   = 8'($urandom_range(0, 2));
      cfg_min_white  = CW'($urandom_range(0, 7));
      cfg_max_white  = CW'($urandom_range(0, 7));
      cfg_on_frames  = 8'($urandom_range(0, 3));
      cfg_off_frames = 8'($urandom_range(0, 3));
      w0 = $urandom_range(0, 7);
      send_frame(w0, NPIX, sel);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    chk("final_processed", frames_processed, m_processed);
    chk("final_dropped", frames_dropped, m_dropped);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    chk("global_timeout", cyc, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
